// File: rtl/pipe_isa_pkg.sv
// ISA constants, instruction classes and the decode function for the 16-bit
// five-stage pipeline. Shared by the hazard controller and its scoreboard.
package pipe_isa_pkg;

    localparam int INSTR_W = 16;
    localparam int REG_W   = 3;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int POP_BIT = 10;
    localparam int RD_LO   = 7;
    localparam int RS_LO   = 4;
    localparam int RT_LO   = 1;

    localparam logic [3:0] OP_STACK = 4'b0000;
    localparam logic [3:0] OP_ALU   = 4'b0001;
    localparam logic [3:0] OP_CALL  = 4'b1011;
    localparam logic [3:0] OP_RET   = 4'b1100;

    localparam logic [1:0] PCSEL_SEQ  = 2'd0;
    localparam logic [1:0] PCSEL_BR   = 2'd1;
    localparam logic [1:0] PCSEL_CALL = 2'd2;
    localparam logic [1:0] PCSEL_RET  = 2'd3;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_PUSH,
        CLS_POP,
        CLS_ALU,
        CLS_BRANCH,
        CLS_CALL,
        CLS_RET
    } cls_e;

    typedef struct packed {
        cls_e             cls;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
    } dec_t;

    // Branch opcodes are the sum-of-products over opcode bits 15..12.
    function automatic logic is_branch_op(input logic [3:0] op);
        return (~op[3] & op[2]) | (op[3] & ~op[2] & ~op[1]) |
               (~op[2] & op[1] & ~op[0]) | (~op[3] & ~op[2] & op[1]);
    endfunction

    function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
        dec_t       d;
        logic [3:0] op;
        op        = instr[OP_HI:OP_LO];
        d.cls     = CLS_NOP;
        d.rd      = instr[RD_LO +: REG_W];
        d.rs      = instr[RS_LO +: REG_W];
        d.rt      = instr[RT_LO +: REG_W];
        d.uses_rs = 1'b0;
        d.uses_rt = 1'b0;
        if (op == OP_STACK) begin
            if (instr[POP_BIT]) begin
                d.cls = CLS_POP;
            end else begin
                d.cls     = CLS_PUSH;
                d.uses_rs = 1'b1;
            end
        end else if (op == OP_ALU) begin
            d.cls     = CLS_ALU;
            d.uses_rs = 1'b1;
            d.uses_rt = 1'b1;
        end else if (op == OP_CALL) begin
            d.cls = CLS_CALL;
        end else if (op == OP_RET) begin
            d.cls = CLS_RET;
        end else if (is_branch_op(op)) begin
            d.cls     = CLS_BRANCH;
            d.uses_rs = 1'b1;
        end
        return d;
    endfunction

    function automatic logic is_writer(input cls_e c);
        return (c == CLS_ALU) || (c == CLS_POP);
    endfunction

    function automatic logic uses_mem_port(input cls_e c);
        return (c == CLS_PUSH) || (c == CLS_POP) || (c == CLS_CALL) || (c == CLS_RET);
    endfunction

endpackage

// File: rtl/pipe_hazard_sb.sv
// EX/MEM/WB scoreboard: shifts valid/class/rd of in-flight instructions and
// reports which stages hold a writer whose rd matches the ID sources.
module pipe_hazard_sb
    import pipe_isa_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    input  cls_e                      in_cls_i,
    input  logic [$clog2(NREG)-1:0]   in_rd_i,
    input  logic                      kill_ex_i,
    input  logic [$clog2(NREG)-1:0]   rs_i,
    input  logic [$clog2(NREG)-1:0]   rt_i,
    input  logic                      use_rs_i,
    input  logic                      use_rt_i,
    output logic                      ex_valid_o,
    output cls_e                      ex_cls_o,
    output logic                      mem_valid_o,
    output cls_e                      mem_cls_o,
    output logic [2:0]                match_rs_o,
    output logic [2:0]                match_rt_o
);

    localparam int RW = $clog2(NREG);

    // Index 0 = EX, 1 = MEM, 2 = WB.
    logic [2:0]    vld_q;
    logic [2:0]    vld_d;
    cls_e          cls_q [3];
    logic [RW-1:0] rd_q  [3];

    assign vld_d = {vld_q[1], vld_q[0] & ~kill_ex_i, in_valid_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        cls_q[0] <= in_cls_i;
        rd_q[0]  <= in_rd_i;
        cls_q[1] <= cls_q[0];
        rd_q[1]  <= rd_q[0];
        cls_q[2] <= cls_q[1];
        rd_q[2]  <= rd_q[1];
    end

    always_comb begin
        match_rs_o = '0;
        match_rt_o = '0;
        for (int s = 0; s < 3; s++) begin
            if (vld_q[s] && is_writer(cls_q[s])) begin
                match_rs_o[s] = use_rs_i && (rd_q[s] == rs_i);
                match_rt_o[s] = use_rt_i && (rd_q[s] == rt_i);
            end
        end
    end

    assign ex_valid_o  = vld_q[0];
    assign ex_cls_o    = cls_q[0];
    assign mem_valid_o = vld_q[1];
    assign mem_cls_o   = cls_q[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: redirects, RAW and
// memory-port stalls, plus stall/flush counters. FWD_EN adds forwarding selects.
module pipe_hazard_ctrl
    import pipe_isa_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_dcond,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       pc_sel,
    output logic             mem_grant_data,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [7:0]       flush_events
`ifdef FWD_EN
    ,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`endif
);

    dec_t             id_dec;
    logic             ex_vld;
    logic             mem_vld;
    cls_e             ex_cls;
    cls_e             mem_cls;
    logic [2:0]       match_rs;
    logic [2:0]       match_rt;
    logic             ret_mem;
    logic             call_ex;
    logic             br_taken_ex;
    logic             stack_mem;
    logic             raw_haz;
    logic             redirect;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic [7:0]       flush_q;
    logic [7:0]       flush_d;

    assign id_dec = decode(id_instr);

    pipe_hazard_sb #(.NREG(NREG)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (id_valid && !id_ex_bubble),
        .in_cls_i    (id_dec.cls),
        .in_rd_i     (id_dec.rd),
        .kill_ex_i   (ex_mem_flush),
        .rs_i        (id_dec.rs),
        .rt_i        (id_dec.rt),
        .use_rs_i    (id_dec.uses_rs),
        .use_rt_i    (id_dec.uses_rt),
        .ex_valid_o  (ex_vld),
        .ex_cls_o    (ex_cls),
        .mem_valid_o (mem_vld),
        .mem_cls_o   (mem_cls),
        .match_rs_o  (match_rs),
        .match_rt_o  (match_rt)
    );

    assign ret_mem     = mem_vld && (mem_cls == CLS_RET);
    assign stack_mem   = mem_vld && uses_mem_port(mem_cls);
    assign call_ex     = ex_vld && (ex_cls == CLS_CALL);
    assign br_taken_ex = ex_vld && (ex_cls == CLS_BRANCH) && ex_dcond;

`ifdef FWD_EN
    // Only a pop's data arrives too late to forward into the next EX.
    logic unused_wb_match;
    assign unused_wb_match = match_rs[2] ^ match_rt[2];
    assign raw_haz = id_valid && ex_vld && (ex_cls == CLS_POP) &&
                     (match_rs[0] || match_rt[0]);

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (id_valid) begin
            if (match_rs[0])      fwd_a = FWD_EXMEM;
            else if (match_rs[1]) fwd_a = FWD_MEMWB;
            if (match_rt[0])      fwd_b = FWD_EXMEM;
            else if (match_rt[1]) fwd_b = FWD_MEMWB;
        end
    end
`else
    assign raw_haz = id_valid && ((|match_rs) || (|match_rt));
`endif

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel       = PCSEL_SEQ;
        redirect     = 1'b0;
        if (ret_mem) begin
            pc_sel       = PCSEL_RET;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            redirect     = 1'b1;
        end else if (br_taken_ex || call_ex) begin
            pc_sel       = call_ex ? PCSEL_CALL : PCSEL_BR;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            redirect     = 1'b1;
        end else if (raw_haz || stack_mem) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign mem_grant_data = stack_mem;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (pc_stall && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (redirect && (flush_q != 8'hFF)) flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule
